alu_result_scoreboard: RTL and testbench

//  Synthesisable in-line checker for ALU_standard_calculator_n_bit. Queues golden results, pairs each DUT valid_result with the oldest one, compares them, and keeps counts.

---
 rtl/alu_result_scoreboard.sv | 138 +++++++++++++
 tb/tb_alu_result_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_scoreboard.sv
// alu_result_scoreboard: queues golden ALU results, pairs each DUT result with the oldest one
// and keeps saturating per-op/total/error statistics plus a first-mismatch capture.
module alu_result_scoreboard #(
   parameter int RESULT_WIDTH = 8,
   parameter int OP_WIDTH     = 3,
   parameter int NUM_OPS      = 4,
   parameter int DEPTH        = 16,
   parameter int CNT_WIDTH    = 16,
   parameter int TIMEOUT      = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          exp_valid,
   output logic                          exp_ready,
   input  logic [RESULT_WIDTH-1:0]       exp_data,
   input  logic [OP_WIDTH-1:0]           exp_op,
   input  logic                          dut_valid,
   input  logic [RESULT_WIDTH-1:0]       dut_result,
   output logic [$clog2(DEPTH):0]        pending,
   output logic [NUM_OPS*CNT_WIDTH-1:0]  match_cnt,
   output logic [CNT_WIDTH-1:0]          total_match,
   output logic [CNT_WIDTH-1:0]          mismatch_cnt,
   output logic [CNT_WIDTH-1:0]          unexpected_cnt,
   output logic [CNT_WIDTH-1:0]          timeout_cnt,
   output logic                          overflow,
   output logic                          err_valid,
   output logic [RESULT_WIDTH-1:0]       err_exp,
   output logic [RESULT_WIDTH-1:0]       err_got,
   output logic [OP_WIDTH-1:0]           err_op,
   output logic                          pass
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam int EW = OP_WIDTH + RESULT_WIDTH;
   typedef logic [CNT_WIDTH-1:0] cnt_t;

   logic [EW-1:0]           mem_q [DEPTH];
   logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW-1:0]           cnt_q, cnt_d;
   logic [WW-1:0]           wd_q, wd_d;
   cnt_t [NUM_OPS-1:0]      match_q, match_d;
   cnt_t                    total_q, total_d, mism_q, mism_d, unexp_q, unexp_d, tmo_q, tmo_d;
   logic                    ovf_q, ovf_d, errv_q, errv_d, pass_q, pass_d;
   logic [RESULT_WIDTH-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
   logic [OP_WIDTH-1:0]     err_op_q, err_op_d;
   logic [OP_WIDTH-1:0]     head_op;
   logic [RESULT_WIDTH-1:0] head_data;
   logic                    full, have, push, cmp, eq, tmo, pop, cap;

   function automatic cnt_t sat(input cnt_t v, input logic en);
      return (en && !(&v)) ? v + cnt_t'(1) : v;
   endfunction

   assign full              = cnt_q == PW'(DEPTH);
   assign have              = cnt_q != '0;
   assign exp_ready         = !full;
   assign push              = exp_valid && !full;
   assign {head_op, head_data} = mem_q[rptr_q];
   assign cmp               = dut_valid && have;
   assign eq                = dut_result == head_data;
   // a DUT result arriving on the expiry cycle takes precedence over the watchdog
   assign tmo               = have && !dut_valid && wd_q == WW'(TIMEOUT - 1);
   assign pop               = cmp || tmo;
   assign cap               = cmp && !eq && !errv_q;

   always_comb begin
      wptr_d = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q + PW'(push) - PW'(pop);
      wd_d   = (pop || !have) ? '0 : wd_q + WW'(1);
      for (int k = 0; k < NUM_OPS; k++)
         match_d[k] = sat(match_q[k], cmp && eq && 32'(head_op) == 32'(k));
      total_d   = sat(total_q, cmp && eq);
      mism_d    = sat(mism_q, cmp && !eq);
      unexp_d   = sat(unexp_q, dut_valid && !have);
      tmo_d     = sat(tmo_q, tmo);
      ovf_d     = ovf_q || (exp_valid && full);
      errv_d    = errv_q || cap;
      err_exp_d = cap ? head_data : err_exp_q;
      err_got_d = cap ? dut_result : err_got_q;
      err_op_d  = cap ? head_op : err_op_q;
      pass_d    = !ovf_d && mism_d == '0 && unexp_d == '0 && tmo_d == '0 && cnt_d == '0;
   end

   always_ff @(posedge clk)
      if (push) mem_q[wptr_q] <= {exp_op, exp_data};

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         wd_q      <= '0;
         match_q   <= '0;
         total_q   <= '0;
         mism_q    <= '0;
         unexp_q   <= '0;
         tmo_q     <= '0;
         ovf_q     <= 1'b0;
         errv_q    <= 1'b0;
         err_exp_q <= '0;
         err_got_q <= '0;
         err_op_q  <= '0;
         pass_q    <= 1'b1;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         wd_q      <= wd_d;
         match_q   <= match_d;
         total_q   <= total_d;
         mism_q    <= mism_d;
         unexp_q   <= unexp_d;
         tmo_q     <= tmo_d;
         ovf_q     <= ovf_d;
         errv_q    <= errv_d;
         err_exp_q <= err_exp_d;
         err_got_q <= err_got_d;
         err_op_q  <= err_op_d;
         pass_q    <= pass_d;
      end
   end

   assign pending        = cnt_q;
   assign match_cnt      = match_q;
   assign total_match    = total_q;
   assign mismatch_cnt   = mism_q;
   assign unexpected_cnt = unexp_q;
   assign timeout_cnt    = tmo_q;
   assign overflow       = ovf_q;
   assign err_valid      = errv_q;
   assign err_exp        = err_exp_q;
   assign err_got        = err_got_q;
   assign err_op         = err_op_q;
   assign pass           = pass_q;
endmodule

// File: tb/tb_alu_result_scoreboard.sv
// tb_alu_result_scoreboard: directed and random stimulus checked against a queue-based model
// of the scoreboard, using a small configuration so overflow, timeout and saturation are reachable.
module tb_alu_result_scoreboard;
   localparam int RW = 8, OW = 3, NO = 4, DP = 4, CW = 4, TO = 8;
   localparam int PW = $clog2(DP) + 1;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 0, rst = 0, clear = 0, exp_valid = 0, dut_valid = 0;
   logic [RW-1:0] exp_data = 0, dut_result = 0;
   logic [OW-1:0] exp_op = 0;
   logic exp_ready, overflow, err_valid, pass;
   logic [PW-1:0] pending;
   logic [NO*CW-1:0] match_cnt;
   logic [CW-1:0] total_match, mismatch_cnt, unexpected_cnt, timeout_cnt;
   logic [RW-1:0] err_exp, err_got;
   logic [OW-1:0] err_op;

   alu_result_scoreboard #(.RESULT_WIDTH(RW), .OP_WIDTH(OW), .NUM_OPS(NO), .DEPTH(DP),
                           .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .clear(clear), .exp_valid(exp_valid), .exp_ready(exp_ready),
      .exp_data(exp_data), .exp_op(exp_op), .dut_valid(dut_valid), .dut_result(dut_result),
      .pending(pending), .match_cnt(match_cnt), .total_match(total_match),
      .mismatch_cnt(mismatch_cnt), .unexpected_cnt(unexpected_cnt), .timeout_cnt(timeout_cnt),
      .overflow(overflow), .err_valid(err_valid), .err_exp(err_exp), .err_got(err_got),
      .err_op(err_op), .pass(pass));

   always #5 clk = ~clk;

   logic [OW+RW-1:0] q[$];
   int m_match[NO];
   int m_total, m_mis, m_unx, m_tmo, m_wait;
   bit m_ovf, m_errv;
   logic [RW-1:0] m_eexp, m_egot;
   logic [OW-1:0] m_eop;
   int compared = 0, mismatched = 0;

   function automatic int inc(int c);
      return c < MAXC ? c + 1 : c;
   endfunction

   task automatic model_reset;
      q.delete();
      foreach (m_match[k]) m_match[k] = 0;
      m_total = 0; m_mis = 0; m_unx = 0; m_tmo = 0; m_wait = 0;
      m_ovf = 0; m_errv = 0; m_eexp = 0; m_egot = 0; m_eop = 0;
   endtask

   task automatic model_edge;
      logic [OW+RW-1:0] h;
      int n;
      if (!rst || clear) begin
         model_reset();
         return;
      end
      n = q.size();
      if (dut_valid && n > 0) begin
         h = q.pop_front();
         m_wait = 0;
         if (h[RW-1:0] === dut_result) begin
            m_total = inc(m_total);
            if (int'(h[RW+:OW]) < NO) m_match[h[RW+:OW]] = inc(m_match[h[RW+:OW]]);
         end else begin
            m_mis = inc(m_mis);
            if (!m_errv) begin
               m_errv = 1; m_eexp = h[RW-1:0]; m_egot = dut_result; m_eop = h[RW+:OW];
            end
         end
      end else if (dut_valid) m_unx = inc(m_unx);
      else if (n > 0 && m_wait == TO - 1) begin
         void'(q.pop_front());
         m_tmo = inc(m_tmo);
         m_wait = 0;
      end else if (n > 0) m_wait++;
      else m_wait = 0;
      if (exp_valid) begin
         if (n < DP) q.push_back({exp_op, exp_data});
         else m_ovf = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all;
      chk("pending", 32'(pending), q.size());
      chk("exp_ready", 32'(exp_ready), 32'(q.size() != DP));
      for (int k = 0; k < NO; k++) chk($sformatf("match%0d", k), 32'(match_cnt[k*CW +: CW]), m_match[k]);
      chk("total", 32'(total_match), m_total);
      chk("mismatch", 32'(mismatch_cnt), m_mis);
      chk("unexpected", 32'(unexpected_cnt), m_unx);
      chk("timeout", 32'(timeout_cnt), m_tmo);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_valid", 32'(err_valid), 32'(m_errv));
      chk("err_exp", 32'(err_exp), 32'(m_eexp));
      chk("err_got", 32'(err_got), 32'(m_egot));
      chk("err_op", 32'(err_op), 32'(m_eop));
      chk("pass", 32'(pass), 32'(m_mis == 0 && m_unx == 0 && m_tmo == 0 && !m_ovf && q.size() == 0));
   endtask

   task automatic step(input bit ev, input logic [OW-1:0] op, input logic [RW-1:0] d,
                       input bit dv, input logic [RW-1:0] r);
      exp_valid = ev; exp_op = op; exp_data = d; dut_valid = dv; dut_result = r;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      exp_valid = 0; dut_valid = 0;
   endtask

   function automatic logic [RW-1:0] head_data;
      return q.size() > 0 ? q[0][RW-1:0] : RW'($urandom);
   endfunction

   task automatic do_clear;
      clear = 1;
      step(0, 0, 0, 0, 0);
      clear = 0;
   endtask

   initial begin
      model_reset();
      rst = 0;
      step(0, 0, 0, 0, 0);
      step(1, 1, 8'h33, 1, 8'h44);
      rst = 1;
      step(0, 0, 0, 0, 0);
      chk("rst_pass", 32'(pass), 1);
      // two matching results on different ops
      step(1, 0, 8'h05, 0, 0);
      step(1, 2, 8'hF4, 0, 0);
      step(0, 0, 0, 1, 8'h05);
      step(0, 0, 0, 1, 8'hF4);
      chk("t1_total", 32'(total_match), 2);
      chk("t1_op2", 32'(match_cnt[2*CW +: CW]), 1);
      // first mismatch is captured, a later one is not
      step(1, 3, 8'h02, 0, 0);
      step(0, 0, 0, 1, 8'h03);
      step(1, 1, 8'h10, 0, 0);
      step(0, 0, 0, 1, 8'h11);
      chk("t2_exp", 32'(err_exp), 32'h02);
      chk("t2_got", 32'(err_got), 32'h03);
      chk("t2_op", 32'(err_op), 3);
      // result on empty queue with a simultaneous push does not pair with it
      do_clear();
      step(1, 5, 8'hAA, 1, 8'hAA);
      chk("t3_unexp", 32'(unexpected_cnt), 1);
      chk("t3_pending", 32'(pending), 1);
      // overflow, then keep serving the head
      do_clear();
      for (int i = 0; i < DP + 1; i++) step(1, OW'($urandom), RW'($urandom), 0, 0);
      chk("t4_ready", 32'(exp_ready), 0);
      chk("t4_ovf", 32'(overflow), 1);
      for (int i = 0; i < 12; i++) step(1, OW'($urandom), RW'($urandom), 1, head_data());
      chk("t4_tmo", 32'(timeout_cnt), 0);
      // watchdog expiry, then a result arriving on the expiry cycle
      do_clear();
      step(1, 1, 8'h42, 0, 0);
      for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0);
      chk("t5_tmo", 32'(timeout_cnt), 1);
      chk("t5_pending", 32'(pending), 0);
      step(1, 1, 8'h43, 0, 0);
      for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 8'h43);
      chk("t5_tmo2", 32'(timeout_cnt), 1);
      chk("t5_match", 32'(match_cnt[1*CW +: CW]), 1);
      // saturation, clear and reset mid-stream
      do_clear();
      for (int i = 0; i < 20; i++) begin
         step(1, OW'(i % NO), RW'(i), 0, 0);
         step(0, 0, 0, 1, RW'(i));
      end
      chk("t6_sat", 32'(total_match), MAXC);
      do_clear();
      chk("t6_clr", 32'(total_match), 0);
      step(1, 2, 8'h77, 0, 0);
      step(1, 2, 8'h78, 1, 8'h00);
      rst = 0;
      step(1, 3, 8'h79, 1, 8'h78);
      rst = 1;
      chk("t6_rst_pend", 32'(pending), 0);
      chk("t6_rst_pass", 32'(pass), 1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         clear = $urandom_range(0, 99) == 0;
         rst = $urandom_range(0, 149) != 0;
         step($urandom_range(0, 1) == 1, OW'($urandom), RW'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0 ? head_data() : RW'($urandom));
      end
      clear = 0; rst = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
